// File: rtl/rgb_gray_pipeline.sv
// rgb_gray_pipeline: weighted RGB-to-luminance with gray / binary / inverted / bypass output modes.
// Latency: 3 cycles for every output; side-band and color outputs stay aligned with out_gray.
// Backpressure: none; one sample per cycle, in_valid = 0 samples flow through like any other.
module rgb_gray_pipeline #(
  parameter int DW      = 10,
  parameter int CW      = 10,
  parameter int COEF_R  = 306,
  parameter int COEF_G  = 601,
  parameter int COEF_B  = 117,
  parameter int THR_RST = 2 ** (DW - 1),
  localparam int CFGW   = (CW > DW) ? CW : DW
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic            in_visual,
  input  logic            in_done,
  input  logic [DW-1:0]   in_red,
  input  logic [DW-1:0]   in_green,
  input  logic [DW-1:0]   in_blue,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_sel,
  input  logic [CFGW-1:0] cfg_data,
  output logic            out_valid,
  output logic            out_visual,
  output logic            out_done,
  output logic [DW-1:0]   out_red,
  output logic [DW-1:0]   out_green,
  output logic [DW-1:0]   out_blue,
  output logic [DW-1:0]   out_gray,
  output logic            out_sat
);

  // Product, sum and integer-luminance widths. The sum has two guard bits so
  // three full-scale products plus the rounding half can never wrap.
  localparam int PW = DW + CW;
  localparam int SW = DW + CW + 2;
  localparam int GW = SW - CW;

  localparam logic [DW-1:0] MAXV = {DW{1'b1}};
  localparam logic [SW-1:0] HALF = SW'(1) << (CW - 1);

  localparam logic [CW-1:0] RST_COEF_R = CW'(COEF_R);
  localparam logic [CW-1:0] RST_COEF_G = CW'(COEF_G);
  localparam logic [CW-1:0] RST_COEF_B = CW'(COEF_B);
  localparam logic [DW-1:0] RST_THR    = DW'(THR_RST);

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_BIN  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_BYP  = 2'd3
  } mode_t;

  // Everything that must ride alongside a sample: side-band strobes, the raw
  // colors, and the output settings captured when the sample entered.
  typedef struct packed {
    logic          valid;
    logic          visual;
    logic          done;
    logic [DW-1:0] red;
    logic [DW-1:0] green;
    logic [DW-1:0] blue;
    mode_t         mode;
    logic [DW-1:0] thr;
  } meta_t;

  // Shadow (written by cfg) and active (used by the datapath) settings.
  logic [CW-1:0] shd_coef_r, shd_coef_g, shd_coef_b;
  logic [DW-1:0] shd_thr;
  mode_t         shd_mode;
  logic [CW-1:0] act_coef_r, act_coef_g, act_coef_b;
  logic [DW-1:0] act_thr;
  mode_t         act_mode;

  // Shadow contents after this cycle's write; also what an end-of-frame
  // transfer copies, so a write coinciding with in_done lands in both.
  logic [CW-1:0] nxt_coef_r, nxt_coef_g, nxt_coef_b;
  logic [DW-1:0] nxt_thr;
  mode_t         nxt_mode;

  logic [PW-1:0] prod_r, prod_g, prod_b;
  meta_t         meta_in;

  logic [PW-1:0] s1_prod_r, s1_prod_g, s1_prod_b;
  meta_t         s1_meta;

  logic [SW-1:0] s2_sum;
  meta_t         s2_meta;

  logic [GW-1:0] g_full;
  logic          g_clip_flag;
  logic [DW-1:0] g_clip;
  logic [DW-1:0] gray_nxt;
  logic          sat_nxt;

  // Fractional bits of the sum only feed the rounding; they are dropped here.
  logic          unused_sum_lsbs;
  assign unused_sum_lsbs = ^s2_sum[CW-1:0];

  // Decode a configuration write into the next shadow values; sel 5-7 are no-ops.
  always_comb begin
    nxt_coef_r = shd_coef_r;
    nxt_coef_g = shd_coef_g;
    nxt_coef_b = shd_coef_b;
    nxt_thr    = shd_thr;
    nxt_mode   = shd_mode;
    if (cfg_we) begin
      case (cfg_sel)
        3'd0:    nxt_coef_r = cfg_data[CW-1:0];
        3'd1:    nxt_coef_g = cfg_data[CW-1:0];
        3'd2:    nxt_coef_b = cfg_data[CW-1:0];
        3'd3:    nxt_thr    = cfg_data[DW-1:0];
        3'd4:    nxt_mode   = mode_t'(cfg_data[1:0]);
        default: ;
      endcase
    end
  end

  // Shadow registers track every write; reset reloads the build-time defaults.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shd_coef_r <= RST_COEF_R;
      shd_coef_g <= RST_COEF_G;
      shd_coef_b <= RST_COEF_B;
      shd_thr    <= RST_THR;
      shd_mode   <= MODE_GRAY;
    end else begin
      shd_coef_r <= nxt_coef_r;
      shd_coef_g <= nxt_coef_g;
      shd_coef_b <= nxt_coef_b;
      shd_thr    <= nxt_thr;
      shd_mode   <= nxt_mode;
    end
  end

  // Active registers change only at end of frame, so a frame never sees mixed settings.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      act_coef_r <= RST_COEF_R;
      act_coef_g <= RST_COEF_G;
      act_coef_b <= RST_COEF_B;
      act_thr    <= RST_THR;
      act_mode   <= MODE_GRAY;
    end else if (in_done) begin
      act_coef_r <= nxt_coef_r;
      act_coef_g <= nxt_coef_g;
      act_coef_b <= nxt_coef_b;
      act_thr    <= nxt_thr;
      act_mode   <= nxt_mode;
    end
  end

  // Stage 1 inputs: full-precision products and the side-band bundle.
  always_comb begin
    prod_r  = PW'(act_coef_r) * PW'(in_red);
    prod_g  = PW'(act_coef_g) * PW'(in_green);
    prod_b  = PW'(act_coef_b) * PW'(in_blue);
    meta_in = '{valid:  in_valid,
                visual: in_visual,
                done:   in_done,
                red:    in_red,
                green:  in_green,
                blue:   in_blue,
                mode:   act_mode,
                thr:    act_thr};
  end

  // Stage 1: register products and capture the settings this sample will use.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_prod_r <= '0;
      s1_prod_g <= '0;
      s1_prod_b <= '0;
      s1_meta   <= '0;
    end else begin
      s1_prod_r <= prod_r;
      s1_prod_g <= prod_g;
      s1_prod_b <= prod_b;
      s1_meta   <= meta_in;
    end
  end

  // Stage 2: sum the products with a rounding half-LSB.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s2_sum  <= '0;
      s2_meta <= '0;
    end else begin
      s2_sum  <= SW'(s1_prod_r) + SW'(s1_prod_g) + SW'(s1_prod_b) + HALF;
      s2_meta <= s1_meta;
    end
  end

  // Stage 3 logic: scale back to DW bits, clip, then apply the sample's own mode.
  always_comb begin
    g_full      = s2_sum[SW-1:CW];
    g_clip_flag = (g_full > GW'(MAXV));
    g_clip      = g_clip_flag ? MAXV : g_full[DW-1:0];
    gray_nxt    = g_clip;
    sat_nxt     = g_clip_flag;
    case (s2_meta.mode)
      MODE_GRAY: gray_nxt = g_clip;
      MODE_BIN:  gray_nxt = (g_clip >= s2_meta.thr) ? MAXV : '0;
      MODE_INV:  gray_nxt = MAXV - g_clip;
      MODE_BYP: begin
        gray_nxt = s2_meta.green;
        sat_nxt  = 1'b0;
      end
      default: ;
    endcase
  end

  // Stage 3: output registers, everything aligned to the same sample.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_visual <= 1'b0;
      out_done   <= 1'b0;
      out_red    <= '0;
      out_green  <= '0;
      out_blue   <= '0;
      out_gray   <= '0;
      out_sat    <= 1'b0;
    end else begin
      out_valid  <= s2_meta.valid;
      out_visual <= s2_meta.visual;
      out_done   <= s2_meta.done;
      out_red    <= s2_meta.red;
      out_green  <= s2_meta.green;
      out_blue   <= s2_meta.blue;
      out_gray   <= gray_nxt;
      out_sat    <= sat_nxt;
    end
  end

endmodule
